// File: rtl/os_pe_row_stream.sv
// Output-stationary row of N MAC PEs with a systolic fmap shift chain.
// Each tile accepts K beats, then drains the N accumulators one per handshake.
module os_pe_row_stream #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int N     = 4,
    parameter int K     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   acc_keep,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        fmap_in,
    input  logic [N*IN_W-1:0]      kernel_in,
    output logic [IN_W-1:0]        fmap_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [OUT_W-1:0]       res_data,
    output logic [$clog2(N)-1:0]   res_idx,
    output logic                   res_last,
    output logic                   busy,
    output logic                   done
);

    localparam int IW = $clog2(N);
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            done_q, done_d;
    logic [IN_W-1:0] fp_q [N];
    logic [IN_W-1:0] fp_d [N];
    logic [OUT_W-1:0] acc_q [N];
    logic [OUT_W-1:0] acc_d [N];

    logic signed [IN_W-1:0]     x    [N];
    logic signed [2*IN_W-1:0]   prod [N];
    logic [2*IN_W+OUT_W-1:0]    pext [N];

    logic beat;
    logic last_idx;

    assign in_ready  = (state_q == COMPUTE);
    assign beat      = in_valid & in_ready;
    assign last_idx  = (idx_q == IW'(N - 1));
    assign res_valid = (state_q == DRAIN);
    assign res_last  = res_valid & last_idx;
    assign res_idx   = idx_q;
    assign res_data  = res_valid ? acc_q[idx_q] : '0;
    assign fmap_out  = fp_q[N-1];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // PE i sees the fmap delayed by i beats; PE0 takes it straight off the input.
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_pe
            if (g == 0) begin : g_head
                assign x[g] = fmap_in;
            end else begin : g_tail
                assign x[g] = fp_q[g-1];
            end
            assign prod[g] = x[g] * $signed(kernel_in[g*IN_W +: IN_W]);
            assign pext[g] = {{OUT_W{prod[g][2*IN_W-1]}}, prod[g]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        fp_d    = fp_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                    for (int i = 0; i < N; i++) begin
                        fp_d[i] = '0;
                        if (!acc_keep) acc_d[i] = '0;
                    end
                end
            end
            COMPUTE: begin
                if (beat) begin
                    fp_d[0] = fmap_in;
                    for (int i = 1; i < N; i++) fp_d[i] = fp_q[i-1];
                    for (int i = 0; i < N; i++) begin
                        acc_d[i] = acc_q[i] + pext[i][OUT_W-1:0];
                    end
                    if (cnt_q == CW'(K - 1)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (res_ready) begin
                    if (last_idx) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                fp_q[i]  <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            fp_q    <= fp_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_os_pe_row_stream.sv
// Scoreboard bench for os_pe_row_stream (N=4, K=8, IN_W=16, OUT_W=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_os_pe_row_stream;

    typedef struct packed {
        logic        last;
        logic [1:0]  idx;
        logic [31:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        acc_keep = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] fmap_in = '0;
    logic [63:0] kernel_in = '0;
    logic [15:0] fmap_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [1:0]  res_idx;
    logic        res_last;
    logic        busy;
    logic        done;

    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t got_q[$];
    res_t hold_q[$];
    logic done_seen;

    os_pe_row_stream #(.IN_W(16), .OUT_W(32), .N(4), .K(8)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_keep(acc_keep),
        .in_valid(in_valid), .in_ready(in_ready), .fmap_in(fmap_in),
        .kernel_in(kernel_in), .fmap_out(fmap_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .res_last(res_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        exp_q.push_back('{last: 1'b0, idx: 2'd0, data: d0});
        exp_q.push_back('{last: 1'b0, idx: 2'd1, data: d1});
        exp_q.push_back('{last: 1'b0, idx: 2'd2, data: d2});
        exp_q.push_back('{last: 1'b1, idx: 2'd3, data: d3});
    endtask

    task automatic do_start(input logic keep);
        start    = 1'b1;
        acc_keep = keep;
        @(negedge clk);
        start    = 1'b0;
        acc_keep = 1'b0;
    endtask

    task automatic send_tile(input logic [15:0] f0, input logic [15:0] step,
                             input logic [15:0] k, input int gap,
                             input int nb, input int start_at);
        kernel_in = {4{k}};
        for (int b = 0; b < nb; b++) begin
            int t = 0;
            fmap_in  = f0 + 16'(b) * step;
            in_valid = 1'b1;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout beat=%0d in_ready=%0b want 1", b, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            if (b == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic collect(input int hold_idx, input int hold_cycles);
        int t = 0;
        int held = 0;
        got_q.delete();
        hold_q.delete();
        done_seen = 1'b0;
        res_ready = 1'b1;
        while (got_q.size() < 4 && t < 200) begin
            if (res_valid) begin
                if (int'(res_idx) == hold_idx && held < hold_cycles) begin
                    res_ready = 1'b0;
                    held++;
                    hold_q.push_back('{last: res_last, idx: res_idx, data: res_data});
                end else begin
                    res_ready = 1'b1;
                    got_q.push_back('{last: res_last, idx: res_idx, data: res_data});
                end
            end
            @(negedge clk);
            t++;
        end
        res_ready = 1'b0;
        if (got_q.size() < 4) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d want 4", got_q.size());
        end
        done_seen = done & ~busy & ~res_valid;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, busy, res_valid, res_last, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want 00000",
                     {in_ready, busy, res_valid, res_last, done});
        end
        checks++;
        if (res_data !== 32'd0 || res_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_res data=%0d idx=%0d want 0 0", res_data, res_idx);
        end
        checks++;
        if (fmap_out !== 16'd0) begin
            failures++;
            $display("FAIL reset_fmap_out got=%0d want 0", fmap_out);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        push_exp(32'd72, 32'd56, 32'd42, 32'd30);
        do_start(1'b0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_compute busy=%b in_ready=%b want 1 1", busy, in_ready);
        end
        send_tile(16'd1, 16'd1, 16'd2, 0, 8, -1);
        collect(-1, 0);
        while (exp_q.size() > 0) begin
            res_t e = exp_q.pop_front();
            res_t g;
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL basic_missing idx=%0d", e.idx);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL basic_res got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b",
                             g.data, g.idx, g.last, e.data, e.idx, e.last);
                end
            end
        end
        checks++;
        if (done_seen !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got=%b want 1", done_seen);
        end
        checks++;
        if (fmap_out !== 16'd5) begin
            failures++;
            $display("FAIL basic_fmap_out got=%0d want 5", fmap_out);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b want 0", done);
        end
    endtask

    task automatic test_stall_backpressure;
        push_exp(32'd72, 32'd56, 32'd42, 32'd30);
        do_start(1'b0);
        send_tile(16'd1, 16'd1, 16'd2, 2, 8, -1);
        collect(1, 3);
        checks++;
        if (hold_q.size() != 3) begin
            failures++;
            $display("FAIL stall_hold_cycles got=%0d want 3", hold_q.size());
        end
        while (hold_q.size() > 0) begin
            res_t h = hold_q.pop_front();
            checks++;
            if (h.data !== 32'd56 || h.idx !== 2'd1) begin
                failures++;
                $display("FAIL stall_hold got d=%0d i=%0d want d=56 i=1", h.data, h.idx);
            end
        end
        while (exp_q.size() > 0) begin
            res_t e = exp_q.pop_front();
            res_t g;
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL stall_missing idx=%0d", e.idx);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL stall_res got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b",
                             g.data, g.idx, g.last, e.data, e.idx, e.last);
                end
            end
        end
        checks++;
        if (done_seen !== 1'b1) begin
            failures++;
            $display("FAIL stall_done got=%b want 1", done_seen);
        end
    endtask

    task automatic test_wrap;
        // PE i sees 8-i beats of 2^30: 2^33, 7*2^30, 6*2^30, 5*2^30 mod 2^32
        push_exp(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 32'h4000_0000);
        do_start(1'b0);
        send_tile(16'h8000, 16'd0, 16'h8000, 0, 8, -1);
        collect(-1, 0);
        while (exp_q.size() > 0) begin
            res_t e = exp_q.pop_front();
            res_t g;
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL wrap_missing idx=%0d", e.idx);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL wrap_res got d=%h i=%0d l=%0b want d=%h i=%0d l=%0b",
                             g.data, g.idx, g.last, e.data, e.idx, e.last);
                end
            end
        end
    endtask

    task automatic test_accumulate;
        for (int r = 0; r < 3; r++) begin
            if (r == 1) push_exp(32'd144, 32'd112, 32'd84, 32'd60);
            else        push_exp(32'd72, 32'd56, 32'd42, 32'd30);
            do_start(r == 1);
            send_tile(16'd1, 16'd1, 16'd2, 0, 8, -1);
            collect(-1, 0);
            while (exp_q.size() > 0) begin
                res_t e = exp_q.pop_front();
                res_t g;
                checks++;
                if (got_q.size() == 0) begin
                    failures++;
                    $display("FAIL accum_missing run=%0d idx=%0d", r, e.idx);
                end else begin
                    g = got_q.pop_front();
                    if (g !== e) begin
                        failures++;
                        $display("FAIL accum_res run=%0d got d=%0d i=%0d want d=%0d i=%0d",
                                 r, g.data, g.idx, e.data, e.idx);
                    end
                end
            end
            if (r == 0) begin
                // beats offered while idle must not touch the accumulators
                fmap_in   = 16'h1234;
                kernel_in = {4{16'd7}};
                in_valid  = 1'b1;
                repeat (3) @(negedge clk);
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_in_ready got=%b want 0", in_ready);
                end
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid;
        do_start(1'b0);
        send_tile(16'd1, 16'd1, 16'd2, 0, 3, -1);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, res_valid, done} !== 4'b0 || fmap_out !== 16'd0) begin
            failures++;
            $display("FAIL async_reset flags=%b fmap_out=%0d want 0000 0",
                     {busy, in_ready, res_valid, done}, fmap_out);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_exp(32'd72, 32'd56, 32'd42, 32'd30);
        do_start(1'b1);
        send_tile(16'd1, 16'd1, 16'd2, 0, 8, 3);
        collect(-1, 0);
        while (exp_q.size() > 0) begin
            res_t e = exp_q.pop_front();
            res_t g;
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL rstmid_missing idx=%0d", e.idx);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL rstmid_res got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b",
                             g.data, g.idx, g.last, e.data, e.idx, e.last);
                end
            end
        end
        checks++;
        if (done_seen !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_done got=%b want 1", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_backpressure();
        test_wrap();
        test_accumulate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
